// File: rtl/dmem_pkg.sv
// Shared types and constants for the dual-port byte-serial data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD    = 8;
  localparam int MEM_DEPTH_DEFAULT = 128;

  // Big-endian byte select: idx 0 is bits [63:56].
  function automatic logic [7:0] word_byte(input logic [63:0] word, input logic [2:0] idx);
    logic [5:0] sh;
    sh = 6'd56 - {idx, 3'b000};
    return 8'(word >> sh);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two ports sharing one response path.
interface dmem_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr0;
  logic [63:0] addr1;
  logic [63:0] wdata0;
  logic [63:0] wdata1;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [63:0] rdata;

  modport master (output req, we, addr0, addr1, wdata0, wdata1, input ack, err, rdata);
  modport slave  (input req, we, addr0, addr1, wdata0, wdata1, output ack, err, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Combinational one-hot grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a byte-wide data memory, moving one 64-bit word
// as eight big-endian byte cycles with fixed latency.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [2:0] CNT_LAST = 3'(BYTES_PER_WORD - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [55:0]   rbuf_q, rbuf_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          last_grant_q, last_grant_d;

  logic [1:0]    gnt_s;
  logic [63:0]   sel_addr_s;
  logic [63:0]   sel_wdata_s;
  logic          sel_we_s;
  logic          legal_s;

  rr_arbiter2 u_rr (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .gnt        (gnt_s)
  );

  assign sel_addr_s  = gnt_s[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata_s = gnt_s[1] ? bus.wdata1 : bus.wdata0;
  assign sel_we_s    = gnt_s[1] ? bus.we[1]  : bus.we[0];
  // Word aligned and inside the memory; equivalent to addr[63:AW] == 0.
  assign legal_s     = (sel_addr_s[2:0] == 3'b000) && (sel_addr_s < 64'(MEM_DEPTH));

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_d       = port_q;
    we_d         = we_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          port_d       = gnt_s[1];
          last_grant_d = gnt_s[1];
          we_d         = sel_we_s;
          base_d       = sel_addr_s[AW-1:0];
          wdata_d      = sel_wdata_s;
          cnt_d        = 3'd0;
          if (legal_s) begin
            // Outputs are registered, so byte 0 is presented from the grant edge.
            state_d     = XFER;
            mem_we_d    = sel_we_s;
            mem_addr_d  = sel_addr_s[AW-1:0];
            mem_wdata_d = word_byte(sel_wdata_s, 3'd0);
          end else begin
            state_d = RESP;
            ack_d   = gnt_s;
            err_d   = gnt_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        rbuf_d = {rbuf_q[47:0], mem_rdata};
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = 3'd0;
          ack_d   = {port_q, ~port_q};
          if (!we_q) begin
            rdata_d = {rbuf_q, mem_rdata};
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d       = cnt_q + 3'd1;
          mem_we_d    = we_q;
          mem_addr_d  = base_q + AW'({1'b0, cnt_q} + 4'd1);
          mem_wdata_d = word_byte(wdata_q, cnt_q + 3'd1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      base_q       <= {AW{1'b0}};
      wdata_q      <= 64'd0;
      rbuf_q       <= 56'd0;
      rdata_q      <= 64'd0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      mem_addr_q   <= {AW{1'b0}};
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_q       <= port_d;
      we_q         <= we_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 128-byte behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem [128];
  int          we_total = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  dmem_arbiter_if bus_if ();

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [63:0] pat;
    pat = 64'hF0E1D2C3B4A59687;
    if (i >= 8 && i <= 15) return 8'hA0 + 8'(i);
    if (i >= 24 && i <= 31) return pat[8*(31-i) +: 8];
    return 8'h00;
  endfunction

  // Behavioural byte memory with asynchronous read
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Running count of write-strobe cycles
  always @(negedge clk) begin
    if (mem_we) we_total <= we_total + 1;
  end

  function automatic logic [63:0] mem_word(input int b);
    logic [63:0] w;
    w = 64'd0;
    for (int k = 0; k < 8; k++) w = {w[55:0], mem[b+k]};
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ack(output logic [1:0] a, output logic [1:0] e,
                          output logic [63:0] rd, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_if.ack != 2'b00) break;
    end
    a  = bus_if.ack;
    e  = bus_if.err;
    rd = bus_if.rdata;
  endtask

  // Issues one access from IDLE, returns at the negedge of the IDLE cycle after ack.
  task automatic access(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [1:0] ack, output logic [1:0] err,
                        output logic [63:0] rd, output int lat);
    if (p == 0) begin
      bus_if.addr0 = a; bus_if.wdata0 = d;
    end else begin
      bus_if.addr1 = a; bus_if.wdata1 = d;
    end
    bus_if.we[p]  = w;
    bus_if.req[p] = 1'b1;
    wait_ack(ack, err, rd, lat);
    bus_if.req = 2'b00;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [1:0]  a, e;
  logic [63:0] rd;
  int          lat, we0, acks;

  initial begin
    bus_if.req = 2'b00; bus_if.we = 2'b00;
    bus_if.addr0 = 64'd0; bus_if.addr1 = 64'd0;
    bus_if.wdata0 = 64'd0; bus_if.wdata1 = 64'd0;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check_eq("rst_ack", 64'(bus_if.ack), 64'd0);
    check_eq("rst_err", 64'(bus_if.err), 64'd0);
    check_eq("rst_rdata", bus_if.rdata, 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store then load back through the other port
    we0 = we_total;
    access(0, 1'b1, 64'h10, 64'h0123456789ABCDEF, a, e, rd, lat);
    check_eq("st_lat", 64'(lat), 64'd9);
    check_eq("st_ack", 64'(a), 64'h1);
    check_eq("st_err", 64'(e), 64'h0);
    check_eq("st_we_cycles", 64'(we_total - we0), 64'd8);
    check_eq("st_mem", mem_word(16), 64'h0123456789ABCDEF);
    we0 = we_total;
    access(1, 1'b0, 64'h10, 64'd0, a, e, rd, lat);
    check_eq("ld_lat", 64'(lat), 64'd9);
    check_eq("ld_ack", 64'(a), 64'h2);
    check_eq("ld_err", 64'(e), 64'h0);
    check_eq("ld_rdata", rd, 64'h0123456789ABCDEF);
    check_eq("ld_we_cycles", 64'(we_total - we0), 64'd0);

    // Illegal: misaligned, then out of range
    for (int t = 0; t < 2; t++) begin
      we0 = we_total;
      access(0, 1'b1, (t == 0) ? 64'h0C : 64'h80, 64'hDEADBEEFDEADBEEF, a, e, rd, lat);
      check_eq("ill_lat", 64'(lat), 64'd1);
      check_eq("ill_ack", 64'(a), 64'h1);
      check_eq("ill_err", 64'(e), 64'h1);
      check_eq("ill_we_cycles", 64'(we_total - we0), 64'd0);
      check_eq("ill_rdata_hold", rd, 64'h0123456789ABCDEF);
    end
    check_eq("ill_mem_08", mem_word(8), 64'hA8A9AAABACADAEAF);
    check_eq("ill_mem_10", mem_word(16), 64'h0123456789ABCDEF);

    // Round-robin alternation after reset
    do_reset();
    bus_if.we = 2'b00; bus_if.addr0 = 64'h10; bus_if.addr1 = 64'h18;
    bus_if.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, e, rd, lat);
      check_eq("rr_ack", 64'(a), (k % 2 == 0) ? 64'h1 : 64'h2);
      check_eq("rr_lat", 64'(lat), 64'd9);
      check_eq("rr_rdata", rd, (k % 2 == 0) ? 64'h0123456789ABCDEF : 64'hF0E1D2C3B4A59687);
      bus_if.req = bus_if.req & ~a;
      @(negedge clk);
      bus_if.req = (k < 3) ? 2'b11 : 2'b00;
    end
    @(negedge clk);

    // Reset in the 4th transfer cycle of a store
    bus_if.addr0 = 64'h20; bus_if.wdata0 = 64'hFFEEDDCCBBAA9988;
    bus_if.we[0] = 1'b1; bus_if.req[0] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("abort_we_before", 64'(mem_we), 64'd1);
    reset = 1'b1;
    bus_if.req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_mem_we", 64'(mem_we), 64'd0);
    check_eq("abort_ack", 64'(bus_if.ack), 64'd0);
    check_eq("abort_rdata", bus_if.rdata, 64'd0);
    reset = 1'b0;
    acks = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.ack != 2'b00 || mem_we) acks++;
    end
    check_eq("abort_quiet", 64'(acks), 64'd0);
    check_eq("abort_partial", 64'({mem[32], mem[33], mem[34]}), 64'hFFEEDD);
    check_eq("abort_untouched", 64'({mem[36], mem[37], mem[38], mem[39]}), 64'd0);
    access(1, 1'b0, 64'h10, 64'd0, a, e, rd, lat);
    check_eq("post_lat", 64'(lat), 64'd9);
    check_eq("post_ack", 64'(a), 64'h2);
    check_eq("post_rdata", rd, 64'h0123456789ABCDEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
